// File: rtl/draw_port_arbiter_pkg.sv
// Shared types and defaults for the draw-port arbiter: FSM state encoding,
// default pixel-bus widths and the screen geometry they are sized for.
package draw_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int X_W_DEF  = 8;
    localparam int Y_W_DEF  = 7;
    localparam int C_W_DEF  = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/draw_port_arbiter_if.sv
// Pixel-write bus between the draw engines (master) and the arbiter (slave),
// including the arbiter's grant/status outputs.
interface draw_port_arbiter_if
    import draw_port_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int C_W   = C_W_DEF
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     done;
    logic [N_REQ-1:0]     plot_in;
    logic [N_REQ*X_W-1:0] x_in;
    logic [N_REQ*Y_W-1:0] y_in;
    logic [N_REQ*C_W-1:0] c_in;

    logic [N_REQ-1:0]     gnt;
    logic [X_W-1:0]       x_out;
    logic [Y_W-1:0]       y_out;
    logic [C_W-1:0]       colour_out;
    logic                 plot_out;
    logic                 busy;
    logic [ID_W-1:0]      active_id;
    logic                 timeout_err;

    modport master (
        output req, done, plot_in, x_in, y_in, c_in,
        input  gnt, x_out, y_out, colour_out, plot_out, busy, active_id, timeout_err
    );

    modport slave (
        input  req, done, plot_in, x_in, y_in, c_in,
        output gnt, x_out, y_out, colour_out, plot_out, busy, active_id, timeout_err
    );

endinterface

// File: rtl/draw_port_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request strictly above the
// pointer, wrapping around, found by a lowest-set-bit scan of a doubled vector.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);
    localparam logic [2*N_REQ-1:0] ONE = (2*N_REQ)'(1);

    logic [N_REQ-1:0]   above;
    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] lowest;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign above[gi] = (ID_W'(gi) > ptr_i);
        end
    endgenerate

    // Lower half holds only requests past the pointer; upper half is the wrap.
    assign dbl    = {req_i, req_i & above};
    assign lowest = dbl & ~(dbl - ONE);
    assign pick_o = lowest[N_REQ-1:0] | lowest[2*N_REQ-1:N_REQ];
    assign any_o  = |req_i;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_o[i]) idx_o = ID_W'(i);
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Shares the single VGA pixel-write port between N_REQ draw engines with
// optional fixed priority for requester 0, round-robin otherwise, and a hold timeout.
module draw_port_arbiter
    import draw_port_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int C_W     = C_W_DEF,
    parameter int HI_PRI0 = 1,
    parameter int TIMEOUT = 20000
) (
    input  logic                 clk,
    input  logic                 resetn,
    draw_port_arbiter_if.slave   bus
);
    localparam int ID_W = $clog2(N_REQ);

    arb_state_e       state_q;
    logic [ID_W-1:0]  win_q;
    logic [ID_W-1:0]  ptr_q;
    logic [N_REQ-1:0] gnt_q;
    logic [15:0]      cnt_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [C_W-1:0]   c_q;
    logic             plot_q;
    logic             busy_q;
    logic             terr_q;

    logic [N_REQ-1:0] pick_oh;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [N_REQ-1:0] sel_oh_d;
    logic [ID_W-1:0]  sel_idx_d;

    rr_priority_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i  (bus.req),
        .ptr_i  (ptr_q),
        .pick_o (pick_oh),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        sel_oh_d  = pick_oh;
        sel_idx_d = pick_idx;
        if (HI_PRI0 != 0 && bus.req[0]) begin
            sel_oh_d  = N_REQ'(1);
            sel_idx_d = '0;
        end
    end

    logic           g_req, g_done, g_plot, timeout_hit, hold_exit;
    logic [X_W-1:0] g_x;
    logic [Y_W-1:0] g_y;
    logic [C_W-1:0] g_c;

    assign g_req       = bus.req[win_q];
    assign g_done      = bus.done[win_q];
    assign g_plot      = bus.plot_in[win_q];
    assign g_x         = bus.x_in[win_q*X_W +: X_W];
    assign g_y         = bus.y_in[win_q*Y_W +: Y_W];
    assign g_c         = bus.c_in[win_q*C_W +: C_W];
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
    assign hold_exit   = g_done | ~g_req | timeout_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    if (pick_any) begin
                        state_q <= ST_HOLD;
                        win_q   <= sel_idx_d;
                        gnt_q   <= sel_oh_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // The final pixel, even one strobed alongside done, is still forwarded.
                    plot_q <= g_plot;
                    x_q    <= g_x;
                    y_q    <= g_y;
                    c_q    <= g_c;
                    if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                    if (hold_exit) begin
                        state_q <= ST_RELEASE;
                        gnt_q   <= '0;
                        if (timeout_hit) terr_q <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    plot_q  <= 1'b0;
                    ptr_q   <= win_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;
    assign bus.colour_out  = c_q;
    assign bus.plot_out    = plot_q;
    assign bus.busy        = busy_q;
    assign bus.active_id   = win_q;
    assign bus.timeout_err = terr_q;

endmodule
